instr_fetch: RTL and testbench

- Consumer end of the program_counter output: takes instr_addr, fetches the word from instruction memory over a req/ack handshake, and presents it to decode as a valid/ready IF/ID register.
- Drives pc_stall back to the PC so the PC advances only when decode accepts an instruction.
- Sits between program_counter and instruction memory / decode in the RISCV-32 core.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/instr_fetch.sv | 122 ++++++++++++
 tb/tb_instr_fetch.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISCV-32 core definitions: datapath width, reset/flush NOP and the
// instruction-fetch state encoding.
package riscv_pkg;

   localparam int unsigned XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      HOLD,
      DRAIN
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: fetches the word at instr_addr over a req/ack memory
// handshake and holds it in a valid/ready IF/ID register for decode.
module instr_fetch
   import riscv_pkg::*;
#(
   parameter int unsigned          XLEN      = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0]      NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] instr_addr,
   input  logic            flush,
   output logic            pc_stall,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            id_ready,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic            misaligned
);

   fetch_state_t    state, state_nxt;
   logic            mem_req_nxt;
   logic [XLEN-1:0] mem_addr_nxt;
   logic            instr_valid_nxt;
   logic [XLEN-1:0] instr_nxt;
   logic [XLEN-1:0] instr_pc_nxt;
   logic            misaligned_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         instr_valid <= 1'b0;
         instr       <= NOP_INSTR;
         instr_pc    <= '0;
         misaligned  <= 1'b0;
      end else begin
         state       <= state_nxt;
         mem_req     <= mem_req_nxt;
         mem_addr    <= mem_addr_nxt;
         instr_valid <= instr_valid_nxt;
         instr       <= instr_nxt;
         instr_pc    <= instr_pc_nxt;
         misaligned  <= misaligned_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      mem_req_nxt     = mem_req;
      mem_addr_nxt    = mem_addr;
      instr_valid_nxt = instr_valid;
      instr_nxt       = instr;
      instr_pc_nxt    = instr_pc;
      misaligned_nxt  = misaligned;

      case (state)
         IDLE: begin
            // A flush in IDLE only clears the fault; the redirected PC is
            // picked up on the following edge.
            if (flush) begin
               misaligned_nxt = 1'b0;
            end else if (misaligned) begin
               misaligned_nxt = 1'b1;
            end else if (instr_addr[1:0] != 2'b00) begin
               misaligned_nxt = 1'b1;
            end else begin
               mem_addr_nxt = instr_addr;
               mem_req_nxt  = 1'b1;
               state_nxt    = WAIT;
            end
         end

         WAIT: begin
            if (mem_ack) begin
               mem_req_nxt = 1'b0;
               if (flush) begin
                  state_nxt = IDLE;
               end else begin
                  instr_nxt       = mem_rdata;
                  instr_pc_nxt    = mem_addr;
                  instr_valid_nxt = 1'b1;
                  state_nxt       = HOLD;
               end
            end else if (flush) begin
               state_nxt = DRAIN;
            end
         end

         DRAIN: begin
            // Orphaned request must complete before mem_req may drop.
            if (mem_ack) begin
               mem_req_nxt = 1'b0;
               state_nxt   = IDLE;
            end
         end

         HOLD: begin
            if (flush) begin
               instr_valid_nxt = 1'b0;
               instr_nxt       = NOP_INSTR;
               state_nxt       = IDLE;
            end else if (id_ready) begin
               instr_valid_nxt = 1'b0;
               state_nxt       = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign pc_stall = !((state == HOLD) && id_ready && !flush);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a PC model, a programmable-delay memory
// model and a scoreboard of instructions expected to be accepted by decode.
module instr_mem_model (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req,
   input  logic [31:0] mem_addr,
   input  int unsigned ack_delay,
   input  logic        spurious_ack,
   output logic        mem_ack,
   output logic [31:0] mem_rdata
);
   logic [31:0] rom [64];
   int unsigned cnt;

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0013 | (32'(i) << 20);
      rom[0] = 32'h0050_0093;
   end

   always @(posedge clk) begin
      if (rst || !mem_req || mem_ack) cnt <= 0;
      else cnt <= cnt + 1;
   end

   assign mem_ack   = spurious_ack || (mem_req && (cnt == ack_delay));
   assign mem_rdata = rom[mem_addr[7:2]];
endmodule

module tb_instr_fetch;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, id_ready, pc_stall;
   logic        mem_req, mem_ack, instr_valid, misaligned;
   logic [31:0] instr_addr, mem_addr, mem_rdata, instr, instr_pc;
   int unsigned ack_delay;
   logic        spurious_ack;
   logic        pc_load;
   logic [31:0] pc_target;

   typedef struct {
      logic [31:0] word;
      logic [31:0] pc;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [31:0] addr;
      int unsigned delay;
      int unsigned hold;
      logic [31:0] word;
   } vec_t;
   vec_t vecs[4];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Program counter model: redirect load wins, otherwise advance when not stalled.
   always @(posedge clk) begin
      if (rst) instr_addr <= '0;
      else if (pc_load) instr_addr <= pc_target;
      else if (!pc_stall) instr_addr <= instr_addr + 32'd4;
   end

   instr_fetch #(.XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (
      .clk(clk), .rst(rst), .instr_addr(instr_addr), .flush(flush),
      .pc_stall(pc_stall), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .id_ready(id_ready),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .misaligned(misaligned)
   );

   instr_mem_model mem (
      .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
      .ack_delay(ack_delay), .spurious_ack(spurious_ack),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Compare any acceptance happening on the coming edge, then advance to the next negedge.
   task automatic tick();
      exp_t e;
      if (!rst && instr_valid && id_ready && !flush) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL accept_unexpected: got pc %h expected no acceptance", instr_pc);
         end else begin
            e = sb.pop_front();
            chk("accept_instr", instr, e.word);
            chk("accept_pc", instr_pc, e.pc);
         end
      end
      @(negedge clk);
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!instr_valid && n < 60) begin
         tick();
         n++;
      end
      chk(name, 32'(instr_valid), 32'd1);
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      int req;
      ack_delay = v.delay;
      flush     = 1'b1;
      pc_load   = 1'b1;
      pc_target = v.addr;
      sb.push_back('{word: v.word, pc: v.addr});
      tick();
      flush   = 1'b0;
      pc_load = 1'b0;
      chk("flush_clears_valid", 32'(instr_valid), 32'd0);
      chk("flush_nop", instr, NOP_INSTR);
      n   = 0;
      req = 0;
      while (!instr_valid && n < 40) begin
         if (mem_req) begin
            req++;
            chk("req_addr_stable", mem_addr, v.addr);
         end
         tick();
         n++;
      end
      chk("fetch_latency", 32'(n), 32'(v.delay + 2));
      chk("req_cycles", 32'(req), 32'(v.delay + 1));
      chk("hold_instr", instr, v.word);
      chk("hold_pc", instr_pc, v.addr);
      for (int unsigned i = 0; i < v.hold; i++) begin
         spurious_ack = 1'b1;
         chk("bp_stall", 32'(pc_stall), 32'd1);
         chk("bp_no_req", 32'(mem_req), 32'd0);
         tick();
         chk("bp_instr", instr, v.word);
         chk("bp_pc", instr_pc, v.addr);
         chk("bp_valid", 32'(instr_valid), 32'd1);
      end
      spurious_ack = 1'b0;
      id_ready = 1'b1;
      #1;
      chk("accept_stall_low", 32'(pc_stall), 32'd0);
      tick();
      id_ready = 1'b0;
      chk("post_accept_stall", 32'(pc_stall), 32'd1);
      chk("pc_advanced", instr_addr, v.addr + 32'd4);
      wait_valid("refetch_timeout");
   endtask

   initial begin
      int n;
      vecs[0] = '{addr: 32'h08, delay: 2, hold: 0, word: 32'h0020_0013};
      vecs[1] = '{addr: 32'h10, delay: 0, hold: 4, word: 32'h0040_0013};
      vecs[2] = '{addr: 32'h20, delay: 1, hold: 1, word: 32'h0080_0013};
      vecs[3] = '{addr: 32'h04, delay: 0, hold: 0, word: 32'h0010_0013};

      rst = 1'b1; flush = 1'b0; id_ready = 1'b0; pc_load = 1'b0;
      pc_target = '0; ack_delay = 0; spurious_ack = 1'b0;
      @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, NOP_INSTR);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_misaligned", 32'(misaligned), 32'd0);
      chk("rst_stall", 32'(pc_stall), 32'd1);

      // Zero-wait fetch straight out of reset.
      id_ready = 1'b1;
      sb.push_back('{word: 32'h0050_0093, pc: 32'h0});
      rst = 1'b0;
      tick();
      chk("e1_req", 32'(mem_req), 32'd1);
      chk("e1_addr", mem_addr, 32'd0);
      chk("e1_valid", 32'(instr_valid), 32'd0);
      tick();
      chk("e2_valid", 32'(instr_valid), 32'd1);
      chk("e2_instr", instr, 32'h0050_0093);
      chk("e2_pc", instr_pc, 32'd0);
      chk("e2_stall_low", 32'(pc_stall), 32'd0);
      tick();
      chk("e3_stall", 32'(pc_stall), 32'd1);
      chk("e3_valid", 32'(instr_valid), 32'd0);
      id_ready = 1'b0;
      tick();
      chk("e4_req", 32'(mem_req), 32'd1);
      chk("e4_addr", mem_addr, 32'd4);
      tick();
      chk("e5_instr", instr, 32'h0010_0013);
      chk("e5_pc", instr_pc, 32'd4);

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // Flush while WAIT: request drains, its data never reaches instr.
      ack_delay = 2;
      flush = 1'b1; pc_load = 1'b1; pc_target = 32'h24;
      tick();
      flush = 1'b0; pc_load = 1'b0;
      tick();
      chk("fw_req", 32'(mem_req), 32'd1);
      chk("fw_addr", mem_addr, 32'h24);
      flush = 1'b1; pc_load = 1'b1; pc_target = 32'h40;
      tick();
      flush = 1'b0; pc_load = 1'b0;
      sb.push_back('{word: 32'h0100_0013, pc: 32'h40});
      id_ready = 1'b1;
      n = 0;
      while (mem_req && n < 20) begin
         chk("drain_valid", 32'(instr_valid), 32'd0);
         chk("drain_addr", mem_addr, 32'h24);
         tick();
         n++;
      end
      chk("drain_cycles", 32'(n), 32'd2);
      chk("drain_instr_nop", instr, NOP_INSTR);
      chk("drain_valid_after", 32'(instr_valid), 32'd0);
      wait_valid("restart_timeout");
      chk("restart_pc", instr_pc, 32'h40);
      tick();
      id_ready = 1'b0;
      wait_valid("post_restart_timeout");

      // Misaligned PC: sticky fault, cleared by flush.
      flush = 1'b1; pc_load = 1'b1; pc_target = 32'h6;
      tick();
      flush = 1'b0; pc_load = 1'b0;
      chk("mis_not_yet", 32'(misaligned), 32'd0);
      tick();
      chk("mis_set", 32'(misaligned), 32'd1);
      chk("mis_no_req", 32'(mem_req), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mis_sticky", 32'(misaligned), 32'd1);
         chk("mis_no_req_hold", 32'(mem_req), 32'd0);
         chk("mis_stall", 32'(pc_stall), 32'd1);
      end
      ack_delay = 0;
      flush = 1'b1; pc_load = 1'b1; pc_target = 32'h10;
      sb.push_back('{word: 32'h0040_0013, pc: 32'h10});
      tick();
      flush = 1'b0; pc_load = 1'b0;
      chk("mis_cleared", 32'(misaligned), 32'd0);
      tick();
      chk("mis_refetch_req", 32'(mem_req), 32'd1);
      chk("mis_refetch_addr", mem_addr, 32'h10);
      id_ready = 1'b1;
      tick();
      chk("mis_refetch_valid", 32'(instr_valid), 32'd1);
      tick();
      id_ready = 1'b0;
      ack_delay = 5;

      // Reset during WAIT abandons the request.
      tick();
      chk("rw_req", 32'(mem_req), 32'd1);
      tick();
      chk("rw_req2", 32'(mem_req), 32'd1);
      rst = 1'b1;
      tick();
      chk("rw_mem_req", 32'(mem_req), 32'd0);
      chk("rw_mem_addr", mem_addr, 32'd0);
      chk("rw_valid", 32'(instr_valid), 32'd0);
      chk("rw_instr", instr, NOP_INSTR);
      chk("rw_instr_pc", instr_pc, 32'd0);
      rst = 1'b0;
      ack_delay = 0;
      id_ready = 1'b1;
      sb.push_back('{word: 32'h0050_0093, pc: 32'h0});
      wait_valid("post_rst_timeout");
      tick();
      id_ready = 1'b0;
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
